// File: rtl/mii_rx_pkg.sv
// -----------------------------------------------------------------------------
// mii_rx_pkg
// Shared definitions for the MII receive framer: FSM state encoding and the
// nibble / CRC-32 constants used by mii_rx_framer and crc32_d8.
// No ports (package).
// -----------------------------------------------------------------------------
package mii_rx_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    DATA_LO  = 3'd2,
    DATA_HI  = 3'd3,
    DROP     = 3'd4
  } rx_state_e;

  localparam logic [3:0]  NIB_PREAMBLE  = 4'h5;
  localparam logic [3:0]  NIB_SFD       = 4'hD;

  // CRC register is kept MSB-first; data bits are fed LSB first, so a frame
  // with a correct FCS leaves the register at the (non-complemented) residue.
  localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704_DD7B;

endpackage

// File: rtl/crc32_d8.sv
// -----------------------------------------------------------------------------
// crc32_d8
// Byte-wide combinational CRC-32 next-state function (Ethernet polynomial).
// The register is MSB-first; the byte is consumed LSB first, matching MII
// bit order on the wire.
// Ports:
//   crc_in   in  32  current CRC register
//   data     in   8  byte to absorb
//   crc_out  out 32  CRC register after absorbing data
// -----------------------------------------------------------------------------
module crc32_d8
  import mii_rx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] crc_s;

  // Eight serial LFSR steps unrolled into one combinational stage
  always_comb begin
    crc_s = crc_in;
    for (int i = 0; i < 8; i++) begin
      crc_s = {crc_s[30:0], 1'b0} ^ (CRC32_POLY & {32{crc_s[31] ^ data[i]}});
    end
    crc_out = crc_s;
  end

endmodule

// File: rtl/mii_rx_framer.sv
// -----------------------------------------------------------------------------
// mii_rx_framer
// MII receive front end: strips preamble/SFD, assembles nibbles into bytes
// (low nibble first), delimits frames and flags runt, oversize, rx_er and
// alignment errors on the end-of-frame cycle.
// Optional build macro MII_RX_CRC_CHECK_EN adds an FCS residue check.
// Ports:
//   i_clk        in   1  MII rx clock
//   i_rst        in   1  asynchronous active-high reset
//   i_mii_rx_dv  in   1  receive data valid
//   i_mii_rxd    in   4  receive nibble
//   i_mii_rx_er  in   1  receive error
//   o_data_en    out  1  high from first byte through the o_eof cycle
//   o_data_vld   out  1  one-cycle strobe per byte
//   o_data       out  8  assembled byte
//   o_sof        out  1  first byte of a frame
//   o_eof        out  1  last cycle of o_data_en
//   o_frame_err  out  1  frame error, valid with o_eof
//   o_byte_cnt   out 16  byte count of current/last frame (saturating)
// -----------------------------------------------------------------------------
module mii_rx_framer
  import mii_rx_pkg::*;
#(
  parameter int unsigned PREAMBLE_MIN = 7,
  parameter int unsigned MIN_LEN      = 64,
  parameter int unsigned MAX_LEN      = 1518
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_mii_rx_dv,
  input  logic [3:0]  i_mii_rxd,
  input  logic        i_mii_rx_er,
  output logic        o_data_en,
  output logic        o_data_vld,
  output logic [7:0]  o_data,
  output logic        o_sof,
  output logic        o_eof,
  output logic        o_frame_err,
  output logic [15:0] o_byte_cnt
);

  localparam logic [3:0]  PRE_MIN_C = 4'(PREAMBLE_MIN);
  localparam logic [15:0] MIN_LEN_C = 16'(MIN_LEN);
  localparam logic [15:0] MAX_LEN_C = 16'(MAX_LEN);

  rx_state_e   state_r, state_nxt_s;
  logic [3:0]  pre_cnt_r;
  logic [3:0]  lo_nib_r;
  logic        err_sticky_r;
  logic        data_en_r, data_vld_r, sof_r, eof_r, frame_err_r;
  logic [7:0]  data_r;
  logic [15:0] byte_cnt_r;
  logic [15:0] frame_cnt_s;
  logic [15:0] cnt_inc_s;
  logic [7:0]  byte_s;
  logic        byte_take_s, eof_set_s, eof_err_s, crc_bad_s;

  // byte_cnt_r still holds the previous frame until the next sof, so length
  // checks use zero whenever no frame is open.
  assign frame_cnt_s = data_en_r ? byte_cnt_r : 16'd0;
  assign cnt_inc_s   = (byte_cnt_r == 16'hFFFF) ? byte_cnt_r : (byte_cnt_r + 16'd1);
  assign byte_s      = {i_mii_rxd, lo_nib_r};

`ifdef MII_RX_CRC_CHECK_EN
  logic [31:0] crc_r, crc_seed_s, crc_nxt_s;

  // First byte of a frame restarts the CRC from the init value
  always_comb begin
    if (data_en_r) begin
      crc_seed_s = crc_r;
    end else begin
      crc_seed_s = CRC32_INIT;
    end
  end

  crc32_d8 u_crc32_d8 (
    .crc_in  (crc_seed_s),
    .data    (byte_s),
    .crc_out (crc_nxt_s)
  );

  // CRC register, advanced on every delivered byte (FCS included)
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      crc_r <= CRC32_INIT;
    end else if (byte_take_s) begin
      crc_r <= crc_nxt_s;
    end else begin
      crc_r <= crc_r;
    end
  end

  assign crc_bad_s = (crc_r != CRC32_RESIDUE);
`else
  assign crc_bad_s = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state, byte capture and end-of-frame decisions
  always_comb begin
    state_nxt_s = state_r;
    byte_take_s = 1'b0;
    eof_set_s   = 1'b0;
    eof_err_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_mii_rx_dv) begin
          if (i_mii_rxd == NIB_PREAMBLE) begin
            state_nxt_s = PREAMBLE;
          end else begin
            state_nxt_s = DROP;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PREAMBLE: begin
        if (!i_mii_rx_dv) begin
          state_nxt_s = IDLE;
        end else if (i_mii_rx_er) begin
          state_nxt_s = DROP;
        end else if (i_mii_rxd == NIB_PREAMBLE) begin
          state_nxt_s = PREAMBLE;
        end else if ((i_mii_rxd == NIB_SFD) && (pre_cnt_r >= PRE_MIN_C)) begin
          state_nxt_s = DATA_LO;
        end else begin
          state_nxt_s = DROP;
        end
      end
      DATA_LO: begin
        if (i_mii_rx_dv) begin
          state_nxt_s = DATA_HI;
        end else begin
          // A frame that never produced a byte closes silently
          state_nxt_s = IDLE;
          eof_set_s   = data_en_r;
          eof_err_s   = err_sticky_r | (frame_cnt_s < MIN_LEN_C) | crc_bad_s;
        end
      end
      DATA_HI: begin
        if (i_mii_rx_dv) begin
          if (frame_cnt_s >= MAX_LEN_C) begin
            // Byte MAX_LEN+1 is discarded and the frame is cut here
            state_nxt_s = DROP;
            eof_set_s   = 1'b1;
            eof_err_s   = 1'b1;
          end else begin
            state_nxt_s = DATA_LO;
            byte_take_s = 1'b1;
          end
        end else begin
          // Odd nibble count
          state_nxt_s = IDLE;
          eof_set_s   = data_en_r;
          eof_err_s   = 1'b1;
        end
      end
      DROP: begin
        if (i_mii_rx_dv) begin
          state_nxt_s = DROP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Preamble counter, low-nibble latch and sticky rx_er flag
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pre_cnt_r    <= 4'd0;
      lo_nib_r     <= 4'd0;
      err_sticky_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          // Leaving IDLE always means one 0x5 nibble has been seen
          pre_cnt_r    <= 4'd1;
          err_sticky_r <= 1'b0;
        end
        PREAMBLE: begin
          err_sticky_r <= 1'b0;
          if ((i_mii_rxd == NIB_PREAMBLE) && (pre_cnt_r != 4'hF)) begin
            pre_cnt_r <= pre_cnt_r + 4'd1;
          end else begin
            pre_cnt_r <= pre_cnt_r;
          end
        end
        DATA_LO: begin
          if (i_mii_rx_dv) begin
            lo_nib_r <= i_mii_rxd;
          end else begin
            lo_nib_r <= lo_nib_r;
          end
          if (i_mii_rx_dv && i_mii_rx_er) begin
            err_sticky_r <= 1'b1;
          end else begin
            err_sticky_r <= err_sticky_r;
          end
        end
        DATA_HI: begin
          if (i_mii_rx_dv && i_mii_rx_er) begin
            err_sticky_r <= 1'b1;
          end else begin
            err_sticky_r <= err_sticky_r;
          end
        end
        default: begin
          pre_cnt_r    <= pre_cnt_r;
          err_sticky_r <= err_sticky_r;
        end
      endcase
    end
  end

  // Registered byte stream and frame delimiters
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      data_en_r   <= 1'b0;
      data_vld_r  <= 1'b0;
      data_r      <= 8'h00;
      sof_r       <= 1'b0;
      eof_r       <= 1'b0;
      frame_err_r <= 1'b0;
      byte_cnt_r  <= 16'd0;
    end else begin
      data_vld_r  <= byte_take_s;
      sof_r       <= byte_take_s & ~data_en_r;
      eof_r       <= eof_set_s;
      frame_err_r <= eof_set_s & eof_err_s;
      if (byte_take_s) begin
        data_r     <= byte_s;
        data_en_r  <= 1'b1;
        byte_cnt_r <= data_en_r ? cnt_inc_s : 16'd1;
      end else if (eof_r) begin
        // Enable drops right after the eof cycle
        data_en_r  <= 1'b0;
      end else begin
        data_en_r  <= data_en_r;
      end
    end
  end

  assign o_data_en   = data_en_r;
  assign o_data_vld  = data_vld_r;
  assign o_data      = data_r;
  assign o_sof       = sof_r;
  assign o_eof       = eof_r;
  assign o_frame_err = frame_err_r;
  assign o_byte_cnt  = byte_cnt_r;

endmodule

// File: tb/tb_mii_rx_framer.sv
// -----------------------------------------------------------------------------
// tb_mii_rx_framer
// Self-checking bench for mii_rx_framer: frames are described by their
// payload and error knobs, a reference model derives the expected byte
// stream and per-frame results, and a negedge monitor records what the DUT
// delivered. Build with MII_RX_CRC_CHECK_EN to include the FCS check.
// -----------------------------------------------------------------------------
module tb_mii_rx_framer;

  localparam int PRE_MIN = 7;
  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;
`ifdef MII_RX_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        dv;
  logic [3:0]  rxd;
  logic        er;
  logic        o_data_en, o_data_vld, o_sof, o_eof, o_frame_err;
  logic [7:0]  o_data;
  logic [15:0] o_byte_cnt;

  mii_rx_framer #(
    .PREAMBLE_MIN (PRE_MIN),
    .MIN_LEN      (MIN_LEN),
    .MAX_LEN      (MAX_LEN)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_mii_rx_dv (dv),
    .i_mii_rxd   (rxd),
    .i_mii_rx_er (er),
    .o_data_en   (o_data_en),
    .o_data_vld  (o_data_vld),
    .o_data      (o_data),
    .o_sof       (o_sof),
    .o_eof       (o_eof),
    .o_frame_err (o_frame_err),
    .o_byte_cnt  (o_byte_cnt)
  );

  always #20 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] pay[$];
  int exp_byte_q[$], exp_run_q[$], exp_err_q[$], exp_cnt_q[$], exp_len_q[$];
  int exp_frames = 0;
  int exp_hold   = 0;
  int got_byte_q[$], got_run_q[$], got_err_q[$], got_cnt_q[$], got_len_q[$];
  int got_shape_q[$], got_sof_q[$], got_rise_q[$];

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: record delivered bytes and per-frame results mid-cycle
  logic en_prev = 1'b0;
  int   run_len = 0;
  always @(negedge clk) begin
    if (o_data_en && !en_prev) got_rise_q.push_back(1);
    en_prev <= o_data_en;
    run_len <= o_data_en ? run_len + 1 : 0;
    if (o_data_vld) begin
      got_byte_q.push_back(int'(o_data));
      got_run_q.push_back(int'(o_byte_cnt));
    end
    if (o_sof) got_sof_q.push_back(int'(o_data_vld));
    if (o_eof) begin
      got_err_q.push_back(int'(o_frame_err));
      got_cnt_q.push_back(int'(o_byte_cnt));
      got_len_q.push_back(run_len + 1);
      got_shape_q.push_back(int'({o_data_en, o_data_vld}));
    end
  end

  // Standard reflected Ethernet CRC-32 with final inversion
  function automatic logic [31:0] crc32_std(input logic [7:0] q[$], input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bit fcs_ok(input logic [7:0] q[$]);
    int n;
    logic [31:0] c;
    n = q.size();
    if (n < 4) return 1'b0;
    c = crc32_std(q, n - 4);
    return c == {q[n-1], q[n-2], q[n-3], q[n-4]};
  endfunction

  task automatic make_pay(input int n_data, input bit incr, input bit add_fcs);
    logic [31:0] c;
    pay.delete();
    for (int i = 0; i < n_data; i++) pay.push_back(incr ? 8'(i) : 8'($urandom));
    if (add_fcs) begin
      c = crc32_std(pay, pay.size());
      pay.push_back(c[7:0]);
      pay.push_back(c[15:8]);
      pay.push_back(c[23:16]);
      pay.push_back(c[31:24]);
    end
  endtask

  // Reference model: what one driven frame must produce
  task automatic model_frame(input int n_pre, input logic [3:0] sfd, input int er_byte, input bit odd);
    int n, d;
    bit err;
    logic [7:0] dq[$];
    if (n_pre >= PRE_MIN && sfd == 4'hD) begin
      n = pay.size();
      d = (n > MAX_LEN) ? MAX_LEN : n;
      for (int i = 0; i < d; i++) begin
        dq.push_back(pay[i]);
        exp_byte_q.push_back(int'(pay[i]));
        exp_run_q.push_back(i + 1);
      end
      err = (d < MIN_LEN) || (er_byte >= 0) || odd || (n > MAX_LEN) || (CRC_EN && !fcs_ok(dq));
      exp_err_q.push_back(int'(err));
      exp_cnt_q.push_back(d);
      exp_len_q.push_back(2 * d + ((odd || n > MAX_LEN) ? 1 : 0));
      exp_frames++;
      exp_hold = d;
    end
  endtask

  task automatic nib(input logic v, input logic [3:0] d, input logic e);
    @(posedge clk);
    #1;
    dv  = v;
    rxd = d;
    er  = e;
  endtask

  task automatic drive_frame(input int n_pre, input logic [3:0] sfd, input int er_byte,
                             input bit odd, input int gap);
    logic [7:0] b;
    model_frame(n_pre, sfd, er_byte, odd);
    for (int i = 0; i < n_pre; i++) nib(1'b1, 4'h5, 1'b0);
    nib(1'b1, sfd, 1'b0);
    for (int i = 0; i < pay.size(); i++) begin
      b = pay[i];
      nib(1'b1, b[3:0], i == er_byte);
      nib(1'b1, b[7:4], 1'b0);
    end
    if (odd) nib(1'b1, 4'($urandom), 1'b0);
    for (int i = 0; i < gap; i++) nib(1'b0, 4'h0, 1'b0);
  endtask

  task automatic compare_all(input string tag);
    int bad0, nb;
    repeat (6) @(posedge clk);
    #1;
    bad0 = n_bad;
    check_val({tag, "_n_bytes"}, got_byte_q.size(), exp_byte_q.size());
    nb = (got_byte_q.size() < exp_byte_q.size()) ? got_byte_q.size() : exp_byte_q.size();
    for (int i = 0; i < nb; i++) begin
      check_val({tag, "_byte"}, got_byte_q[i], exp_byte_q[i]);
      check_val({tag, "_run_cnt"}, got_run_q[i], exp_run_q[i]);
      if (n_bad > bad0 + 4) break;
    end
    check_val({tag, "_n_sof"}, got_sof_q.size(), exp_frames);
    foreach (got_sof_q[i]) check_val({tag, "_sof_with_vld"}, got_sof_q[i], 1);
    check_val({tag, "_n_en_rise"}, got_rise_q.size(), exp_frames);
    check_val({tag, "_n_eof"}, got_err_q.size(), exp_err_q.size());
    for (int i = 0; i < got_err_q.size() && i < exp_err_q.size(); i++) begin
      check_val({tag, "_err"}, got_err_q[i], exp_err_q[i]);
      check_val({tag, "_cnt"}, got_cnt_q[i], exp_cnt_q[i]);
      check_val({tag, "_en_len"}, got_len_q[i], exp_len_q[i]);
      check_val({tag, "_eof_en_novld"}, got_shape_q[i], 2);
    end
    check_val({tag, "_cnt_hold"}, int'(o_byte_cnt), exp_hold);
    exp_byte_q.delete(); exp_run_q.delete(); exp_err_q.delete();
    exp_cnt_q.delete(); exp_len_q.delete();
    got_byte_q.delete(); got_run_q.delete(); got_err_q.delete(); got_cnt_q.delete();
    got_len_q.delete(); got_shape_q.delete(); got_sof_q.delete(); got_rise_q.delete();
    exp_frames = 0;
  endtask

  initial begin
    logic [7:0] save[$];
    logic [7:0] b;
    int n, npre, erb;
    bit fcs, odd;

    rst = 1'b1; dv = 1'b0; rxd = 4'h0; er = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_data_en", int'(o_data_en), 0);
    check_val("rst_vld", int'(o_data_vld), 0);
    check_val("rst_data", int'(o_data), 0);
    check_val("rst_sof", int'(o_sof), 0);
    check_val("rst_eof", int'(o_eof), 0);
    check_val("rst_err", int'(o_frame_err), 0);
    check_val("rst_cnt", int'(o_byte_cnt), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Legal 64-byte frame: 60 incrementing bytes plus FCS
    make_pay(60, 1'b1, 1'b1);
    drive_frame(15, 4'hD, -1, 1'b0, 3);
    compare_all("legal64");

    // Short preamble is dropped; a new frame right after a 1-cycle gap is accepted
    make_pay(70, 1'b0, 1'b1);
    drive_frame(5, 4'hD, -1, 1'b0, 1);
    make_pay(64, 1'b0, 1'b1);
    drive_frame(7, 4'hD, -1, 1'b0, 3);
    compare_all("short_pre");

    // Runt
    make_pay(56, 1'b0, 1'b1);
    drive_frame(15, 4'hD, -1, 1'b0, 3);
    compare_all("runt60");

    // Oversize stream is cut at MAX_LEN
    make_pay(1600, 1'b0, 1'b0);
    drive_frame(15, 4'hD, -1, 1'b0, 3);
    compare_all("oversize");

    // rx_er at byte 20, then an odd nibble count
    make_pay(96, 1'b0, 1'b1);
    drive_frame(15, 4'hD, 20, 1'b0, 2);
    make_pay(76, 1'b0, 1'b1);
    drive_frame(15, 4'hD, -1, 1'b1, 3);
    compare_all("rxer_odd");

    // Corrupted FCS, then the intact frame
    make_pay(70, 1'b0, 1'b1);
    save = pay;
    b = pay[pay.size() - 2];
    pay[pay.size() - 2] = b ^ 8'h10;
    drive_frame(15, 4'hD, -1, 1'b0, 2);
    pay = save;
    drive_frame(15, 4'hD, -1, 1'b0, 3);
    compare_all("fcs");

    // Back-to-back frames with a single idle cycle
    make_pay(80, 1'b0, 1'b1);
    drive_frame(9, 4'hD, -1, 1'b0, 1);
    make_pay(66, 1'b0, 1'b1);
    drive_frame(7, 4'hD, -1, 1'b0, 1);
    compare_all("b2b");

    // Reset in the middle of a frame: ten bytes out, no eof
    make_pay(30, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      exp_byte_q.push_back(int'(pay[i]));
      exp_run_q.push_back(i + 1);
    end
    exp_frames = 1;
    for (int i = 0; i < 15; i++) nib(1'b1, 4'h5, 1'b0);
    nib(1'b1, 4'hD, 1'b0);
    for (int i = 0; i < 10; i++) begin
      b = pay[i];
      nib(1'b1, b[3:0], 1'b0);
      nib(1'b1, b[7:4], 1'b0);
    end
    b = pay[10];
    nib(1'b1, b[3:0], 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_val("midrst_data_en", int'(o_data_en), 0);
    check_val("midrst_cnt", int'(o_byte_cnt), 0);
    check_val("midrst_data", int'(o_data), 0);
    check_val("midrst_eof", int'(o_eof), 0);
    dv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_hold = 0;
    compare_all("midrst");

    // Randomized frames
    for (int f = 0; f < 10; f++) begin
      n    = int'($urandom_range(56, 140));
      fcs  = ($urandom_range(0, 3) != 0);
      make_pay(n, 1'b0, fcs);
      npre = ($urandom_range(0, 5) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(7, 15));
      erb  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, pay.size() - 1)) : -1;
      odd  = ($urandom_range(0, 4) == 0);
      drive_frame(npre, 4'hD, erb, odd, int'($urandom_range(1, 4)));
      compare_all("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
